// File: rtl/serial_subtractor_if.sv
//------------------------------------------------------------------------------
// Module      : serial_subtractor_if
// Description : Operand/result handshake bundle for serial_subtractor.
//               The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module      : serial_subtractor
// Description : Bit-serial a - b - bin, LSB first, one bit per clock.
//               Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input wire                 clk,
  input wire                 rst_n,
  serial_subtractor_if.slave bus
);

  localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_out_valid;
  logic               r_in_ready;

  logic               w_d;
  logic               w_br_next;

  // Full-subtractor on the current LSBs of the shifting operand registers
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_br        <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_br       <= bus.bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_br   <= w_br_next;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_cnt  <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last) begin
            r_bout      <= w_br_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the operand LSBs are the original sign bits
            r_ovf       <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_subtractor
// Description : Directed and back-to-back random checks of serial_subtractor.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] ed, input logic eb,
                              input logic eo);
    check({tag, "_diff"}, bus.diff, ed);
    check({tag, "_bout"}, bus.bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, bus.ovf, eo);
`else
    if (eo === 1'bx) $display("unused ovf expectation");
`endif
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_rdy"}, bus.in_ready, 1);
    bus.a        = ta;
    bus.b        = tb_v;
    bus.bin      = tbin;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out_valid(lat);
    check({tag, "_lat"}, lat, WIDTH);
    check_result(tag, ed, eb, eo);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
  endtask

  initial begin
    int       lat;
    logic [7:0] ra, rb, ed;
    logic       rbin, eb, eo;
    logic [8:0] full;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_state", {bus.in_ready, bus.out_valid, bus.bout, bus.diff}, {3'b100, 8'h00});
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif

    // Directed vectors: diff, bout, ovf worked out by hand
    do_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    do_op("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    do_op("v10_10b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op("v7F_01", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
    do_op("vFF_FFb", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("v00_80", 8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1);
    do_op("vAA_55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

    // Backpressure: DONE must hold while inputs keep changing
    bus.a = 8'h3C; bus.b = 8'h0F; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < WIDTH + 1 && bus.out_valid !== 1'b1; i++) begin
      bus.a = bus.a ^ 8'hFF;
      bus.b = bus.b ^ 8'h5A;
      @(posedge clk); #1;
    end
    check("bp_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      bus.a   = bus.a ^ 8'hFF;
      bus.b   = bus.b ^ 8'h5A;
      bus.bin = ~bus.bin;
      @(posedge clk); #1;
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.bout, bus.diff}, {3'b100, 8'h2D});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
    @(posedge clk); #1;
    check("bp_no_accept", bus.in_ready, 1);

    // Reset asserted on the 4th RUN edge
    bus.a = 8'h55; bus.b = 8'h11; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst", {bus.in_ready, bus.out_valid, bus.bout, bus.diff}, {3'b100, 8'h00});
    do_op("post_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // Back-to-back: handshakes tied high, one result every WIDTH+2 edges
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
      ed   = full[7:0];
      eb   = full[8];
      eo   = (ra[7] ^ rb[7]) & (ed[7] ^ ra[7]);
      check("b2b_rdy", bus.in_ready, 1);
      bus.a   = ra;
      bus.b   = rb;
      bus.bin = rbin;
      @(posedge clk); #1;
      wait_out_valid(lat);
      check("b2b_lat", lat, WIDTH);
      check_result("b2b", ed, eb, eo);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_idle", {bus.in_ready, bus.out_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/bin presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
REQ-012 SHALL have port bout  output  1  borrow-out, 1 when a < b + bin (unsigned).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-014 SHALL accept operands on an edge where in_valid and in_ready are both 1: capture a, b, bin; clear bit counter; IDLE -> RUN.
REQ-015 SHALL in RUN process one bit per edge, LSB first, bit i on the (i+1)th edge after acceptance.
REQ-016 SHALL per bit compute d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br initialised to bin.
REQ-017 SHALL after the WIDTH-th RUN edge go RUN -> DONE, bout = final br; out_valid high exactly WIDTH edges after the accepting edge.
REQ-018 SHALL in DONE hold diff, bout, out_valid stable until an edge with out_ready=1, then DONE -> IDLE (in_ready=1 next cycle).
REQ-019 SHALL ignore in_valid and changes on a/b/bin while in RUN or DONE; no accept and deliver in the same cycle.
REQ-020 SHALL keep diff/bout holding the last result in IDLE; they are only meaningful while out_valid=1.
REQ-021 SHALL treat in_valid in IDLE with no prior result normally (first operation after reset needs no warm-up).

Reset
REQ-022 SHALL on an edge with rst_n=0 force state IDLE, counter 0, diff 0, bout 0, out_valid 0, in_ready 1 (from the next cycle).
REQ-023 SHALL abort any RUN/DONE operation on reset with no result delivered; reset takes priority over every handshake.

Configuration
REQ-024 SHALL, when macro SERIAL_SUB_OVF_EN is defined, add port ovf  output  1  signed overflow = (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB]), valid with out_valid, reset 0, held like diff.
REQ-025 SHALL, when SERIAL_SUB_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour identical.

Verification
REQ-026 SHALL cover: a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, out_valid exactly 8 edges after accept.
REQ-027 SHALL cover: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
REQ-028 SHALL cover (SERIAL_SUB_OVF_EN defined): a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
REQ-029 SHALL cover backpressure: out_ready held 0 for 5 cycles after out_valid with in_valid=1 and a/b toggling -> diff/bout/out_valid stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-030 SHALL cover reset mid-RUN: rst_n=0 on 4th RUN edge -> out_valid=0, diff=0, in_ready=1 next cycle; subsequent 0x09-0x04 -> diff=0x05.
REQ-031 SHALL cover back-to-back: out_ready tied 1, in_valid tied 1 -> one result per WIDTH+2 edges, every result correct against a reference model for 1000 random operand pairs.
